poly_horner_eval: RTL and testbench

- Parametrised successor to the fixed quadratic evaluator.
- Evaluates an unsigned polynomial of configurable degree, P(x) = sum c_i * x^i, using Horner's rule.
- One multiply-accumulate step per clock, sequenced by an internal controller.
- Uses the same inicio/ready/valid start-done handshake; adds an overflow flag.
- Sits between the operand registers and the result consumer in the arithmetic datapath.

---
 rtl/poly_horner_eval.sv | 183 ++++++++++++++++++
 tb/tb_poly_horner_eval.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_horner_eval.sv
// -----------------------------------------------------------------------------
// poly_horner_eval
//
// Purpose:
//   Evaluates an unsigned polynomial P(x) = sum c_i * x^i of degree DEGREE
//   using Horner's rule. The datapath performs one multiply-accumulate step
//   per clock, and a small two-state controller sequences the steps. The
//   start/done handshake uses inicio, ready and valid. An overflow flag reports
//   any Horner step that discarded nonzero high bits.
//
// Parameters:
//   DEGREE - polynomial degree (>= 1); DEGREE+1 coefficients
//   XW     - width of operand x
//   CW     - width of each coefficient
//   RW     - width of accumulator and result (RW >= CW)
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   inicio   in   start request, sampled only while ready=1
//   x        in   evaluation point, captured on the accept edge
//   coef     in   flattened coefficients, coef[i*CW +: CW] = c_i
//   result   out  P(x) mod 2^RW, held until the next completion
//   ready    out  controller idle, start can be accepted
//   valid    out  one-cycle pulse marking a new result
//   overflow out  some step of the last evaluation lost high bits
//
// Build option:
//   POLY_HORNER_SAT_EN - when defined, an overflowing evaluation returns
//                        all-ones instead of the wrapped value.
// -----------------------------------------------------------------------------
module poly_horner_eval #(
    parameter int DEGREE = 2,
    parameter int XW     = 8,
    parameter int CW     = 16,
    parameter int RW     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inicio,
    input  logic [XW-1:0]            x,
    input  logic [(DEGREE+1)*CW-1:0] coef,
    output logic [RW-1:0]            result,
    output logic                     ready,
    output logic                     valid,
    output logic                     overflow
);

    // The full width holds acc*x + c without loss. The product needs RW+XW
    // bits, and the extra bit absorbs the carry from adding the coefficient.
    localparam int FW   = RW + XW + 1;
    localparam int CNTW = (DEGREE > 1) ? $clog2(DEGREE) : 1;
    localparam int NCW  = (DEGREE + 1) * CW;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_STEP = 1'b1
    } state_t;

    state_t              state_q,    state_d;
    logic [XW-1:0]       x_q,        x_d;
    logic [NCW-1:0]      coef_q,     coef_d;
    logic [RW-1:0]       acc_q,      acc_d;
    logic [CNTW-1:0]     cnt_q,      cnt_d;
    logic                ovf_q,      ovf_d;
    logic [RW-1:0]       result_q,   result_d;
    logic                ready_q,    ready_d;
    logic                valid_q,    valid_d;
    logic                overflow_q, overflow_d;

    logic [CW-1:0]       coef_sel_s;
    logic [FW-1:0]       full_s;
    logic                step_ovf_s;
    logic [RW-1:0]       final_s;

    // One Horner step on the latched operands: acc*x + c_cnt at full width.
    always_comb begin
        coef_sel_s = coef_q[int'(cnt_q)*CW +: CW];
        full_s     = FW'(acc_q) * FW'(x_q) + FW'(coef_sel_s);
        step_ovf_s = |full_s[FW-1:RW];
    end

    // Select the value published at completion. The saturating build clamps
    // on any overflow. Otherwise the low RW bits are returned as they are.
    always_comb begin
`ifdef POLY_HORNER_SAT_EN
        if (ovf_q | step_ovf_s) begin
            final_s = {RW{1'b1}};
        end else begin
            final_s = full_s[RW-1:0];
        end
`else
        final_s = full_s[RW-1:0];
`endif
    end

    // Controller and datapath next-state logic.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        coef_d     = coef_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        result_d   = result_q;
        ready_d    = ready_q;
        valid_d    = 1'b0;
        overflow_d = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (inicio) begin
                    // Capture the operands now, so that later input changes
                    // cannot disturb the running evaluation.
                    x_d     = x;
                    coef_d  = coef;
                    acc_d   = RW'(coef[DEGREE*CW +: CW]);
                    cnt_d   = CNTW'(DEGREE - 1);
                    ovf_d   = 1'b0;
                    ready_d = 1'b0;
                    state_d = ST_STEP;
                end else begin
                    ready_d = 1'b1;
                end
            end

            ST_STEP: begin
                acc_d = full_s[RW-1:0];
                ovf_d = ovf_q | step_ovf_s;
                if (cnt_q == {CNTW{1'b0}}) begin
                    // The last coefficient has been folded in, so publish the
                    // result. Ready rises in the same cycle as valid, which
                    // allows a back-to-back start.
                    result_d   = final_s;
                    overflow_d = ovf_q | step_ovf_s;
                    valid_d    = 1'b1;
                    ready_d    = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers. An asynchronous reset aborts any evaluation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            x_q        <= {XW{1'b0}};
            coef_q     <= {NCW{1'b0}};
            acc_q      <= {RW{1'b0}};
            cnt_q      <= {CNTW{1'b0}};
            ovf_q      <= 1'b0;
            result_q   <= {RW{1'b0}};
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            coef_q     <= coef_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign result   = result_q;
    assign ready    = ready_q;
    assign valid    = valid_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_poly_horner_eval.sv
// -----------------------------------------------------------------------------
// tb_poly_horner_eval
//
// Directed bench for poly_horner_eval. The main instance is DEGREE=2 with
// RW=16. Two more instances cover DEGREE=1 and DEGREE=5 with RW=32. The
// expected values are computed by hand, and a direct power-sum model checks
// the parameter sweep.
// -----------------------------------------------------------------------------
module tb_poly_horner_eval;

    logic clk;
    logic rst;

    // DEGREE=2, RW=16 instance
    logic        inicio2;
    logic [7:0]  x2;
    logic [47:0] coef2;
    logic [15:0] result2;
    logic        ready2, valid2, ovf2;

    // DEGREE=1, RW=32 instance
    logic        inicio1;
    logic [7:0]  x1;
    logic [31:0] coef1;
    logic [31:0] result1;
    logic        ready1, valid1, ovf1;

    // DEGREE=5, RW=32 instance
    logic        inicio5;
    logic [7:0]  x5;
    logic [95:0] coef5;
    logic [31:0] result5;
    logic        ready5, valid5, ovf5;

    int n_checks = 0;
    int n_fails  = 0;

    poly_horner_eval #(.DEGREE(2), .XW(8), .CW(16), .RW(16)) u_dut2 (
        .clk(clk), .rst(rst), .inicio(inicio2), .x(x2), .coef(coef2),
        .result(result2), .ready(ready2), .valid(valid2), .overflow(ovf2)
    );

    poly_horner_eval #(.DEGREE(1), .XW(8), .CW(16), .RW(32)) u_dut1 (
        .clk(clk), .rst(rst), .inicio(inicio1), .x(x1), .coef(coef1),
        .result(result1), .ready(ready1), .valid(valid1), .overflow(ovf1)
    );

    poly_horner_eval #(.DEGREE(5), .XW(8), .CW(16), .RW(32)) u_dut5 (
        .clk(clk), .rst(rst), .inicio(inicio5), .x(x5), .coef(coef5),
        .result(result5), .ready(ready5), .valid(valid5), .overflow(ovf5)
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Direct sum c_i * x^i mod 2^32 (not Horner form)
    function automatic logic [31:0] ref_poly(input int deg, input logic [7:0] xv, input logic [95:0] cf);
        longint unsigned sum;
        longint unsigned pw;
        longint unsigned c;
        sum = 64'd0;
        pw  = 64'd1;
        for (int i = 0; i <= deg; i++) begin
            c   = 64'(cf[i*16 +: 16]);
            sum = (sum + c * pw) & 64'h0000_0000_FFFF_FFFF;
            pw  = (pw * 64'(xv)) & 64'h0000_0000_FFFF_FFFF;
        end
        return sum[31:0];
    endfunction

    // Pulse inicio for one cycle on the DEGREE=2 instance; returns one negedge after accept
    task automatic start2(input logic [7:0] xv, input logic [15:0] c2, input logic [15:0] c1, input logic [15:0] c0);
        @(negedge clk);
        x2      = xv;
        coef2   = {c2, c1, c0};
        inicio2 = 1'b1;
        @(negedge clk);
        inicio2 = 1'b0;
    endtask

    // Count edges after accept until valid2 is seen (bounded)
    task automatic wait2(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!valid2 && lat < 40);
    endtask

    task automatic run1(input logic [7:0] xv, input logic [31:0] cf, input string tag);
        int lat;
        @(negedge clk);
        x1 = xv; coef1 = cf; inicio1 = 1'b1;
        @(negedge clk);
        inicio1 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!valid1 && lat < 40);
        chk({tag, "_lat"}, 64'(lat), 64'd1);
        chk({tag, "_res"}, 64'(result1), 64'(ref_poly(1, xv, {64'd0, cf})));
    endtask

    task automatic run5(input logic [7:0] xv, input logic [95:0] cf, input string tag);
        int lat;
        @(negedge clk);
        x5 = xv; coef5 = cf; inicio5 = 1'b1;
        @(negedge clk);
        inicio5 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!valid5 && lat < 40);
        chk({tag, "_lat"}, 64'(lat), 64'd5);
        chk({tag, "_res"}, 64'(result5), 64'(ref_poly(5, xv, cf)));
    endtask

    initial begin
        int lat;
        int npulse;
        int k_first;
        int k_second;
        logic [15:0] r_first;
        logic [15:0] r_second;

        rst = 1'b1;
        inicio2 = 1'b0; x2 = 8'd0; coef2 = 48'd0;
        inicio1 = 1'b0; x1 = 8'd0; coef1 = 32'd0;
        inicio5 = 1'b0; x5 = 8'd0; coef5 = 96'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(ready2), 64'd1);
        chk("rst_valid", 64'(valid2), 64'd0);
        chk("rst_result", 64'(result2), 64'd0);
        chk("rst_ovf", 64'(ovf2), 64'd0);
        chk("rst_ready1", 64'(ready1), 64'd1);
        chk("rst_ready5", 64'(ready5), 64'd1);
        rst = 1'b0;

        // Basic: 3*25 + 2*5 + 1 = 86
        start2(8'd5, 16'd3, 16'd2, 16'd1);
        chk("basic_busy", 64'(ready2), 64'd0);
        wait2(lat);
        chk("basic_lat", 64'(lat), 64'd2);
        chk("basic_res", 64'(result2), 64'd86);
        chk("basic_ovf", 64'(ovf2), 64'd0);
        chk("basic_ready", 64'(ready2), 64'd1);
        @(negedge clk);
        chk("basic_pulse", 64'(valid2), 64'd0);
        chk("basic_hold", 64'(result2), 64'd86);

        // Overflow: FFFF*2 = 1FFFE -> FFFE, *2 = 1FFFC -> FFFC
        start2(8'd2, 16'hFFFF, 16'd0, 16'd0);
        wait2(lat);
        chk("ovf_lat", 64'(lat), 64'd2);
`ifdef POLY_HORNER_SAT_EN
        chk("ovf_res", 64'(result2), 64'h0000_0000_0000_FFFF);
`else
        chk("ovf_res", 64'(result2), 64'h0000_0000_0000_FFFC);
`endif
        chk("ovf_flag", 64'(ovf2), 64'd1);

        // Reset mid-operation
        start2(8'd5, 16'd3, 16'd2, 16'd1);
        rst = 1'b1;
        #1;
        chk("midrst_ready", 64'(ready2), 64'd1);
        chk("midrst_valid", 64'(valid2), 64'd0);
        chk("midrst_result", 64'(result2), 64'd0);
        chk("midrst_ovf", 64'(ovf2), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        npulse = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (valid2) npulse++;
        end
        chk("midrst_nopulse", 64'(npulse), 64'd0);
        start2(8'd2, 16'd1, 16'd0, 16'd0);
        wait2(lat);
        chk("fresh_lat", 64'(lat), 64'd2);
        chk("fresh_res", 64'(result2), 64'd4);

        // Busy protection: second inicio and coef change during the run
        start2(8'd5, 16'd3, 16'd2, 16'd1);
        inicio2 = 1'b1;
        x2      = 8'd7;
        coef2   = {16'd9, 16'd9, 16'd9};
        npulse = 0; k_first = 0; r_first = 16'd0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) inicio2 = 1'b0;
            if (valid2) begin
                npulse++;
                if (npulse == 1) begin
                    k_first = k;
                    r_first = result2;
                end
            end
        end
        chk("busy_npulse", 64'(npulse), 64'd1);
        chk("busy_lat", 64'(k_first), 64'd2);
        chk("busy_res", 64'(r_first), 64'd86);

        // Back-to-back: x=1 gives 3, then x=0 gives c0=1
        @(negedge clk);
        x2 = 8'd1; coef2 = {16'd1, 16'd1, 16'd1}; inicio2 = 1'b1;
        @(negedge clk);
        x2 = 8'd0;
        npulse = 0; k_first = 0; k_second = 0; r_first = 16'd0; r_second = 16'd0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 3) inicio2 = 1'b0;
            if (valid2) begin
                npulse++;
                if (npulse == 1) begin
                    k_first = k; r_first = result2;
                    chk("b2b_ready", 64'(ready2), 64'd1);
                end else begin
                    k_second = k; r_second = result2;
                    chk("b2b_x0_ovf", 64'(ovf2), 64'd0);
                end
            end
        end
        chk("b2b_npulse", 64'(npulse), 64'd2);
        chk("b2b_first_lat", 64'(k_first), 64'd2);
        chk("b2b_spacing", 64'(k_second - k_first), 64'd3);
        chk("b2b_res1", 64'(r_first), 64'd3);
        chk("b2b_res2", 64'(r_second), 64'd1);

        // All-zero coefficients
        start2(8'd200, 16'd0, 16'd0, 16'd0);
        wait2(lat);
        chk("zero_res", 64'(result2), 64'd0);
        chk("zero_ovf", 64'(ovf2), 64'd0);

        // Parameter sweep against the power-sum model
        run1(8'd7, {16'd10, 16'd3}, "d1_a");
        run1(8'hFF, {16'hFFFF, 16'hFFFF}, "d1_max");
        for (int i = 0; i < 4; i++) begin
            run1(8'($urandom_range(255)), 32'($urandom), "d1_rnd");
        end
        run5(8'd2, {16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1}, "d5_a");
        run5(8'hFF, {6{16'hFFFF}}, "d5_max");
        for (int i = 0; i < 4; i++) begin
            run5(8'($urandom_range(255)), {32'($urandom), 32'($urandom), 32'($urandom)}, "d5_rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
